// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Contents: FSM state enum, default widths, saturation limit and a helper
// that derives the largest representable value for a given digit count.
package bin_bcd_pkg;

    localparam int unsigned BIN_W_DEF  = 10;
    localparam int unsigned DIGITS_DEF = 3;
    localparam int unsigned MAX_VAL    = 999;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    // Largest value that fits in `digits` decimal digits (10^digits - 1).
    function automatic int unsigned max_val_for(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_bcd_if.sv
// Request/result bundle for bin_bcd.
// Ports (signals):
//   in_valid  - request to convert bin          (master -> slave)
//   bin       - unsigned binary value           (master -> slave)
//   in_ready  - converter can accept a request  (slave -> master)
//   bcd       - packed BCD result, units in [3:0] (slave -> master)
//   out_valid - one-cycle pulse, bcd is new     (slave -> master)
//   overflow  - last result was saturated       (slave -> master)
interface bin_bcd_if
    import bin_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) ();

    logic                  in_valid;
    logic [BIN_W-1:0]      bin;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  out_valid;
    logic                  overflow;

    modport master (
        output in_valid, bin,
        input  in_ready, bcd, out_valid, overflow
    );

    modport slave (
        input  in_valid, bin,
        output in_ready, bcd, out_valid, overflow
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble per-digit adjust: adds 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i - 4-bit scratch digit before adjust
//   digit_o - 4-bit adjusted digit
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3). A request is taken in
// IDLE, then one double-dabble step runs per clock for BIN_W clocks. Values
// above 10^DIGITS-1 saturate to all nines and raise overflow.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bin_bcd_if.slave: in_valid/bin in, in_ready/bcd/out_valid/overflow out
module bin_bcd
    import bin_bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input logic        clk,
    input logic        rst_n,
    bin_bcd_if.slave   bus
);

    localparam int unsigned BcdW     = 4 * DIGITS;
    localparam int unsigned CntW     = $clog2(BIN_W + 1);
    localparam int unsigned MaxV     = max_val_for(DIGITS);
    localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]  shreg_q, shreg_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              ready_q, ready_d;

    logic [BcdW-1:0]   adj;
    logic [BcdW-1:0]   step_scratch;
    logic              unused_adj_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    // Scratch after one step: adjusted digits shifted left, binary MSB enters.
    // The top bit only matters for saturating inputs, which never use scratch.
    assign step_scratch   = {adj[BcdW-2:0], shreg_q[BIN_W-1]};
    assign unused_adj_msb = adj[BcdW-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        ovf_pend_d  = ovf_pend_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        ready_d     = ready_q;

        case (state_q)
            StIdle: begin
                // First edge after reset raises ready; acceptance needs it already high.
                ready_d = 1'b1;
                if (bus.in_valid && ready_q) begin
                    state_d    = StShift;
                    shreg_d    = bus.bin;
                    cnt_d      = '0;
                    scratch_d  = '0;
                    ovf_pend_d = 64'(bus.bin) > 64'(MaxV);
                    ready_d    = 1'b0;
                end
            end
            StShift: begin
                shreg_d   = shreg_q << 1;
                scratch_d = step_scratch;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CntW'(BIN_W - 1)) begin
                    state_d     = StIdle;
                    ready_d     = 1'b1;
                    out_valid_d = 1'b1;
                    bcd_d       = ovf_pend_q ? AllNines : step_scratch;
                    ovf_d       = ovf_pend_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            scratch_q   <= '0;
            ovf_pend_q  <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            ovf_pend_q  <= ovf_pend_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.bcd       = bcd_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_bin_bcd.sv
// Self-checking bench for bin_bcd: a driver pushes expected results into a
// scoreboard queue at acceptance; a monitor pops and compares on out_valid.
module tb_bin_bcd;

    localparam int unsigned BIN_W  = 10;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned LAT    = 10;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int unsigned acc_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    exp_t        sb[$];
    logic [11:0] last_bcd;
    logic        last_ovf;

    bin_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [11:0] model_bcd(input int unsigned v);
        int unsigned s;
        s = (v > 999) ? 999 : v;
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic push_exp(input int unsigned v, input int unsigned c);
        exp_t e;
        e.bcd     = model_bcd(v);
        e.ovf     = (v > 999);
        e.acc_cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Drive one request, hold it for the accepting edge, then scramble bin.
    task automatic send(input int unsigned v);
        @(negedge clk);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.bin      = BIN_W'(v);
        @(posedge clk);
        #1;
        push_exp(v, cyc);
        bus.in_valid = 1'b0;
        bus.bin      = BIN_W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard compare on out_valid, hold check otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_bcd = '0;
            last_ovf = 1'b0;
        end else if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                logic legal;
                e = sb.pop_front();
                legal = 1'b1;
                for (int d = 0; d < DIGITS; d++) begin
                    if (bus.bcd[4*d +: 4] > 4'd9) legal = 1'b0;
                end
                check_eq("bcd", 32'(bus.bcd), 32'(e.bcd));
                check_eq("overflow", 32'(bus.overflow), 32'(e.ovf));
                check_eq("latency", cyc - e.acc_cyc, LAT);
                check_eq("bcd_legal", 32'(legal), 32'd1);
            end
            last_bcd = bus.bcd;
            last_ovf = bus.overflow;
        end else begin
            check_eq("bcd_hold", 32'(bus.bcd), 32'(last_bcd));
            check_eq("ovf_hold", 32'(bus.overflow), 32'(last_ovf));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.bin      = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_bcd", 32'(bus.bcd), 32'h0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Basic values, small and mid-range, boundary and saturation.
        send(0);
        send(1);
        send(9);
        send(10);
        send(59);
        send(123);
        send(999);
        send(1001);
        send(5);
        drain();

        // in_valid held through SHIFT with changing bin; next accept in out_valid cycle.
        @(negedge clk);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.bin      = 10'd321;
        @(posedge clk);
        #1;
        push_exp(321, cyc);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 30) begin
            bus.bin = BIN_W'($urandom);
            @(negedge clk);
            n++;
        end
        check_eq("ready_in_out_valid_cycle", 32'(bus.out_valid), 32'd1);
        bus.bin = 10'd777;
        @(posedge clk);
        #1;
        push_exp(777, cyc);
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-conversion aborts the request.
        send(123);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_bcd", 32'(bus.bcd), 32'h0);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_overflow", 32'(bus.overflow), 32'd0);
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        send(59);
        drain();

        // Full input range.
        for (int i = 0; i < 1024; i++) begin
            send(i);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_bcd.md
BIN_BCD -- requirements
Module: bin_bcd

Interface
REQ-001 Parameter BIN_W, default 10, binary input width.
REQ-002 Parameter DIGITS, default 3, BCD output digits; output width 4*DIGITS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request to convert bin.
REQ-006 bin  input  BIN_W  unsigned binary value.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 bcd  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
REQ-009 out_valid  output  1  one-cycle pulse, bcd holds a new result.
REQ-010 overflow  output  1  last result was saturated.

Function
REQ-011 States IDLE and SHIFT only; in_ready SHALL be 1 exactly in IDLE.
REQ-012 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; bin is captured, shift counter cleared, BCD scratch cleared, state goes to SHIFT.
REQ-013 in_valid while in SHIFT SHALL be ignored; bin changes after acceptance SHALL not affect the result.
REQ-014 In SHIFT, each edge SHALL perform one double-dabble step: every scratch digit >=5 gets +3, then {scratch, binary} shifts left one bit.
REQ-015 After exactly BIN_W steps (10 edges after acceptance), state SHALL return to IDLE, bcd SHALL load the result, out_valid SHALL be 1 for that one cycle.
REQ-016 Latency: out_valid high in the cycle following the 10th edge after the accepting edge; a new request may be accepted in that same cycle.
REQ-017 If captured bin > 10^DIGITS-1 (999), bcd SHALL be all-nines (0x999) and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-018 overflow SHALL update together with bcd and hold until the next result.
REQ-019 bcd and overflow SHALL hold their value between results, including across ignored requests.
REQ-020 Each bcd digit SHALL always be 0-9; no illegal nibbles ever appear on bcd.

Reset
REQ-021 While rst_n=0: state IDLE, bcd=0x000, out_valid=0, overflow=0, counter and scratch cleared, in_ready=0.
REQ-022 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-023 Reset during SHIFT SHALL abort the conversion; no out_valid for the aborted request.

Structure
REQ-024 Package bin_bcd_pkg SHALL hold the state enum, BIN_W/DIGITS defaults, and the MAX_VAL (999) constant.
REQ-025 One sub-module bcd_add3 SHALL implement the per-digit adjust (4-bit in, 4-bit out, +3 when >=5), instantiated DIGITS times.

Verification
REQ-026 Reset, then requests 0, 1, 9 -> bcd 0x000, 0x001, 0x009, overflow 0, each out_valid exactly 10 cycles after acceptance.
REQ-027 Requests 10, 59, 123 -> bcd 0x010, 0x059, 0x123.
REQ-028 Request 999 -> bcd 0x999, overflow 0; request 1001 -> bcd 0x999, overflow 1; then 5 -> bcd 0x005, overflow 0.
REQ-029 Hold in_valid high with changing bin during SHIFT -> only the accepted value is converted; next acceptance happens in the out_valid cycle.
REQ-030 Assert rst_n=0 mid-conversion of 123 -> outputs zero immediately, no out_valid; next request 59 -> 0x059.
REQ-031 Exhaustive sweep 0..1023 -> bcd matches decimal digits of min(bin, 999) and overflow = (bin > 999).
